mul_share_arbiter: RTL and testbench
====================================

# mul_share_arbiter

Round-robin arbiter and sequencer that shares one 64x64 iterative multiplier among `NREQ` requesters, such as several factorial cores or other arithmetic engines. It sits between the requesters and the single `multiplier` instance. It owns the multiplier's operand, start and clear lines, runs one product at a time, and returns each 128-bit result to the requester that issued it.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `W`, 64: operand width; the result is `2*W` bits wide.

- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester request, level-sensitive.
- `req_a`  in  NREQ*W  packed multiplier operands; requester i uses `[i*W +: W]`.
- `req_b`  in  NREQ*W  packed multiplicand operands, same packing as `req_a`.
- `abort`  in  1  synchronous cancel of the operation in flight.
- `req_ack`  out  NREQ  one-cycle pulse: operands of requester i have been captured.
- `rsp_valid`  out  NREQ  one-cycle pulse: `rsp_data` belongs to requester i.
- `rsp_data`  out  2*W  shared result bus.
- `busy`  out  1  high in every state other than IDLE.
- `m_multiplier`, `m_multiplicand`  out  W  operands driven to the multiplier.
- `m_start`  out  1  multiplier start, held high through RUN.
- `m_clear`  out  1  multiplier clear, one-cycle pulse.
- `m_done`  in  1  multiplier done.
- `m_result`  in  2*W  multiplier product.

## Operation
- All outputs are registered.
- Reset values: every output 0, state IDLE, round-robin pointer `ptr` = 0, grant index `g` = 0.
- States: IDLE, RUN, CLEAR.
- IDLE:
  - If any `req_valid` bit is set, pick the first set bit scanning `ptr`, `ptr+1`, … with wrap modulo NREQ.
  - Latch `g` and that requester's `req_a`/`req_b` into `m_multiplier`/`m_multiplicand`.
  - Go to RUN.
- RUN:
  - `m_start`=1, `busy`=1, `req_ack[g]`=1 in the first RUN cycle only.
  - When `m_done`=1: capture `m_result` into `rsp_data` and go to CLEAR.
- CLEAR (one cycle):
  - `m_start`=0, `m_clear`=1, `rsp_valid[g]`=1.
  - `ptr` <= (g+1) mod NREQ.
  - Go to IDLE.
- `m_done` is ignored in IDLE and CLEAR.
- `abort`=1 in RUN:
  - Next state is CLEAR with `m_clear`=1, but `rsp_valid` stays 0 and `rsp_data` keeps its previous value.
  - `ptr` still advances past `g`.
  - `abort` together with `m_done` in the same cycle: abort wins and no response is issued.
  - `abort` in IDLE or CLEAR has no effect.
- Operand values are used unmodified; the full unsigned 2W-bit product is returned, with no truncation or overflow flag.
- Requesters must deassert `req_valid` no later than the cycle `rsp_valid[i]` is high. A request still held at the next IDLE cycle counts as a new request.
- `rsp_data` holds its value until the next capture.

## Timing
- Cycle 0: IDLE with request visible.
- Cycle 1: RUN begins; `req_ack` pulses and `m_start` rises.
- Multiplier latency L cycles: the cycle after `m_done` is sampled is CLEAR, with `rsp_valid` and `m_clear` high.
- The next cycle is IDLE.
- Grant-to-grant minimum spacing is L+3 cycles; there is no pipelining, so only one operation is ever outstanding.
- Reset mid-operation: all outputs drop immediately to 0, the state returns to IDLE, and no `rsp_valid` is issued.

## Structure
- Package `mul_arb_pkg`:
  - state enum (IDLE, RUN, CLEAR);
  - default `W`;
  - `NREQ` limits.
- Sub-module `rr_pick`: combinational rotating-priority picker. Inputs are `req_valid` and `ptr`; outputs are a found flag and the grant index. It is instantiated once.
- The top level holds the FSM, the operand and result registers, and the multiplier port drive.

## Test plan
The bench uses a multiplier model with fixed latency L=4.

1. Single request: `req_valid`=0001, a=5, b=7 → `req_ack[0]` in cycle 1, `m_start` high for 5 cycles, `rsp_valid[0]` with `rsp_data`=35, `m_clear` pulse, then IDLE.
2. After reset, `req_valid`=1111 held, each bit dropped on its `rsp_valid` → grants in order 0, 1, 2, 3, each spaced L+3 cycles.
3. Requesters 0 and 2 re-request continuously → grants alternate 2, 0, 2, 0 after the first grant 0; no starvation.
4. a=b=FFFF_FFFF_FFFF_FFFF → `rsp_data`=FFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
5. Abort cases:
   - `abort` in the second RUN cycle → CLEAR with `m_clear`=1, no `rsp_valid`, `rsp_data` unchanged, `ptr` advanced.
   - `abort` coinciding with `m_done` → same result.
6. `reset_n` asserted mid-RUN → all outputs 0 asynchronously. After release, a new request to requester 1 is granted from `ptr`=0 and completes normally.

Source files
------------

// File: rtl/mul_share_arbiter_pkg.sv
// Shared definitions for the multiplier-sharing arbiter.
// Contents: FSM state encoding, default operand width, requester-count limits.
package mul_arb_pkg;

    localparam int unsigned W_DEF    = 64;
    localparam int unsigned NREQ_DEF = 4;
    localparam int unsigned NREQ_MIN = 2;
    localparam int unsigned NREQ_MAX = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CLEAR = 2'd2
    } state_t;

endpackage

// File: rtl/mul_share_arbiter_if.sv
// Link between the arbiter and the shared iterative multiplier.
// master: arbiter side (drives operands, start, clear; receives done, result).
// slave : multiplier side.
interface mul_share_arbiter_if
    import mul_arb_pkg::*;
#(
    parameter int unsigned W = W_DEF
);

    logic [W-1:0]   m_multiplier;
    logic [W-1:0]   m_multiplicand;
    logic           m_start;
    logic           m_clear;
    logic           m_done;
    logic [2*W-1:0] m_result;

    modport master (
        output m_multiplier, m_multiplicand, m_start, m_clear,
        input  m_done, m_result
    );

    modport slave (
        input  m_multiplier, m_multiplicand, m_start, m_clear,
        output m_done, m_result
    );

endinterface

// File: rtl/mul_share_arbiter_rr_pick.sv
// Rotating-priority picker: first set req_valid bit scanning ptr, ptr+1, ...
// with wrap modulo NREQ.
// Ports: req_valid, ptr in; found_c (any request), grant_c (index) out.
module rr_pick
    import mul_arb_pkg::*;
#(
    parameter int unsigned NREQ  = NREQ_DEF,
    parameter int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req_valid,
    input  logic [PTR_W-1:0] ptr,
    output logic             found_c,
    output logic [PTR_W-1:0] grant_c
);

    int unsigned idx;

    // Scan in priority order; the first hit wins.
    always_comb begin
        found_c = 1'b0;
        grant_c = '0;
        idx     = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found_c && req_valid[PTR_W'(idx)]) begin
                found_c = 1'b1;
                grant_c = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin sequencer sharing one iterative multiplier among NREQ requesters.
// Ports: clk, reset_n; req_valid/req_a/req_b/abort in; req_ack, rsp_valid,
// rsp_data, busy out (all registered); mul: master side of the multiplier link.
module mul_share_arbiter
    import mul_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned W    = W_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    input  logic                abort,
    output logic [NREQ-1:0]     req_ack,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [2*W-1:0]      rsp_data,
    output logic                busy,
    mul_share_arbiter_if.master mul
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] g_q, g_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             start_q, start_d;
    logic             clear_q, clear_d;
    logic [NREQ-1:0]  ack_d;
    logic [NREQ-1:0]  rspv_d;
    logic [2*W-1:0]   rspd_d;
    logic             busy_d;

    logic             found_c;
    logic [PTR_W-1:0] pick_c;
    logic [W-1:0]     sel_a_c;
    logic [W-1:0]     sel_b_c;

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req_valid (req_valid),
        .ptr       (ptr_q),
        .found_c   (found_c),
        .grant_c   (pick_c)
    );

    // Operand mux for the picked requester.
    always_comb begin
        sel_a_c = '0;
        sel_b_c = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (pick_c == PTR_W'(k)) begin
                sel_a_c = req_a[k*W +: W];
                sel_b_c = req_b[k*W +: W];
            end
        end
    end

    // Next state and next register values.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        g_d     = g_q;
        a_d     = a_q;
        b_d     = b_q;
        start_d = 1'b0;
        clear_d = 1'b0;
        ack_d   = '0;
        rspv_d  = '0;
        rspd_d  = rsp_data;
        case (state_q)
            IDLE: begin
                if (found_c) begin
                    g_d     = pick_c;
                    a_d     = sel_a_c;
                    b_d     = sel_b_c;
                    start_d = 1'b1;
                    ack_d   = NREQ'(1) << pick_c;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Abort takes priority over a simultaneous done.
                if (abort) begin
                    clear_d = 1'b1;
                    state_d = CLEAR;
                end else if (mul.m_done) begin
                    rspd_d  = mul.m_result;
                    rspv_d  = NREQ'(1) << g_q;
                    clear_d = 1'b1;
                    state_d = CLEAR;
                end else begin
                    start_d = 1'b1;
                end
            end
            CLEAR: begin
                ptr_d   = (g_q == PTR_W'(NREQ - 1)) ? '0 : g_q + PTR_W'(1);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            g_q       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            start_q   <= 1'b0;
            clear_q   <= 1'b0;
            req_ack   <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            g_q       <= g_d;
            a_q       <= a_d;
            b_q       <= b_d;
            start_q   <= start_d;
            clear_q   <= clear_d;
            req_ack   <= ack_d;
            rsp_valid <= rspv_d;
            rsp_data  <= rspd_d;
            busy      <= busy_d;
        end
    end

    assign mul.m_multiplier   = a_q;
    assign mul.m_multiplicand = b_q;
    assign mul.m_start        = start_q;
    assign mul.m_clear        = clear_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: fixed-latency multiplier model, directed
// stimulus, scoreboard queues for grants and responses checked by a monitor.
module tb_mul_share_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 64;
    localparam int unsigned L    = 4;

    typedef struct {
        int idx;
        int gap;
    } ack_t;

    typedef struct {
        int           idx;
        logic [127:0] data;
    } rsp_t;

    logic              clk;
    logic              reset_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              abort;
    logic [NREQ-1:0]   req_ack;
    logic [NREQ-1:0]   rsp_valid;
    logic [2*W-1:0]    rsp_data;
    logic              busy;

    mul_share_arbiter_if #(.W(W)) mif ();

    mul_share_arbiter #(
        .NREQ (NREQ),
        .W    (W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .abort     (abort),
        .req_ack   (req_ack),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .mul       (mif.master)
    );

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   last_ack = 0;
    ack_t ack_q[$];
    rsp_t rsp_q[$];
    ack_t ae;
    rsp_t re;
    int unsigned mcnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier model: done rises after L start-high edges.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcnt         <= 0;
            mif.m_done   <= 1'b0;
            mif.m_result <= '0;
        end else if (!mif.m_start || mif.m_clear) begin
            mcnt       <= 0;
            mif.m_done <= 1'b0;
        end else begin
            if (mcnt < L - 1) mcnt <= mcnt + 1;
            else              mif.m_done <= 1'b1;
            mif.m_result <= {64'b0, mif.m_multiplier} * {64'b0, mif.m_multiplicand};
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a grant or response.
    always @(negedge clk) begin
        if (reset_n) begin
            if (req_ack != '0) begin
                if (ack_q.size() == 0) begin
                    chk("ack_unexpected", 128'(req_ack), 128'd0);
                end else begin
                    ae = ack_q.pop_front();
                    chk("ack_idx", 128'(req_ack), 128'(4'b0001 << ae.idx));
                    if (ae.gap > 0) chk("ack_gap", 128'(cyc - last_ack), 128'(ae.gap));
                end
                last_ack = cyc;
            end
            if (rsp_valid != '0) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", 128'(rsp_valid), 128'd0);
                end else begin
                    re = rsp_q.pop_front();
                    chk("rsp_idx", 128'(rsp_valid), 128'(4'b0001 << re.idx));
                    chk("rsp_data", rsp_data, re.data);
                end
            end
        end
    end

    task automatic set_ops(input int idx, input logic [63:0] a, input logic [63:0] b);
        req_a[idx*64 +: 64] = a;
        req_b[idx*64 +: 64] = b;
    endtask

    // Raise requests, wait for the grant, then drop them; returns in the ack cycle.
    task automatic issue(input logic [3:0] mask);
        bit got = 0;
        req_valid = mask;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req_ack != '0) begin
                got = 1;
                break;
            end
        end
        req_valid = '0;
        chk("ack_timeout", 128'(got), 128'd1);
    endtask

    task automatic wait_rsp();
        bit got = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp_valid != '0) begin
                got = 1;
                break;
            end
        end
        chk("rsp_timeout", 128'(got), 128'd1);
    endtask

    // Run until n responses, optionally dropping each answered request.
    task automatic run_rsp(input int n, input bit drop);
        int cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rsp_valid != '0) begin
                cnt++;
                if (drop) req_valid = req_valid & ~rsp_valid;
                if (cnt == n) begin
                    req_valid = '0;
                    break;
                end
            end
        end
        chk("rsp_count", 128'(cnt), 128'(n));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ack"},   128'(req_ack),   128'd0);
        chk({tag, "_rsp_valid"}, 128'(rsp_valid), 128'd0);
        chk({tag, "_rsp_data"},  rsp_data,        128'd0);
        chk({tag, "_busy"},      128'(busy),      128'd0);
        chk({tag, "_m_start"},   128'(mif.m_start), 128'd0);
        chk({tag, "_m_clear"},   128'(mif.m_clear), 128'd0);
        chk({tag, "_m_mplier"},  128'(mif.m_multiplier), 128'd0);
        chk({tag, "_m_mcand"},   128'(mif.m_multiplicand), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int start_cnt;
        bit seen;
        reset_n   = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        abort     = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 128'(busy), 128'd0);

        // 1: single request 5*7
        set_ops(0, 64'd5, 64'd7);
        ack_q.push_back('{0, 0});
        rsp_q.push_back('{0, 128'd35});
        issue(4'b0001);
        chk("t1_start_c1", 128'(mif.m_start), 128'd1);
        chk("t1_busy_c1", 128'(busy), 128'd1);
        start_cnt = 1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid != '0) begin
                seen = 1;
                break;
            end
            if (mif.m_start) start_cnt++;
        end
        chk("t1_rsp_seen", 128'(seen), 128'd1);
        chk("t1_start_cycles", 128'(start_cnt), 128'd5);
        chk("t1_clear", 128'(mif.m_clear), 128'd1);
        chk("t1_start_off", 128'(mif.m_start), 128'd0);
        @(negedge clk);
        chk("t1_idle_busy", 128'(busy), 128'd0);
        chk("t1_clear_pulse", 128'(mif.m_clear), 128'd0);
        chk("t1_rsp_hold", rsp_data, 128'd35);

        // 2: all four held after reset, dropped on response
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        set_ops(0, 64'd3, 64'd11);
        set_ops(1, 64'd1000, 64'd1000);
        set_ops(2, 64'd0, 64'd123);
        set_ops(3, 64'h1_0000_0000, 64'h1_0000_0000);
        ack_q.push_back('{0, 0});
        ack_q.push_back('{1, 7});
        ack_q.push_back('{2, 7});
        ack_q.push_back('{3, 7});
        rsp_q.push_back('{0, 128'd33});
        rsp_q.push_back('{1, 128'd1000000});
        rsp_q.push_back('{2, 128'd0});
        rsp_q.push_back('{3, 128'h1_0000_0000_0000_0000});
        req_valid = 4'b1111;
        run_rsp(4, 1'b1);
        @(negedge clk);
        chk("t2_idle_busy", 128'(busy), 128'd0);

        // 3: requesters 0 and 2 held continuously
        set_ops(0, 64'd2, 64'd3);
        set_ops(2, 64'd7, 64'd8);
        ack_q.push_back('{0, 0});
        ack_q.push_back('{2, 7});
        ack_q.push_back('{0, 7});
        ack_q.push_back('{2, 7});
        ack_q.push_back('{0, 7});
        rsp_q.push_back('{0, 128'd6});
        rsp_q.push_back('{2, 128'd56});
        rsp_q.push_back('{0, 128'd6});
        rsp_q.push_back('{2, 128'd56});
        rsp_q.push_back('{0, 128'd6});
        req_valid = 4'b0101;
        run_rsp(5, 1'b0);
        @(negedge clk);

        // 4: full-width operands
        set_ops(3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        ack_q.push_back('{3, 0});
        rsp_q.push_back('{3, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001});
        issue(4'b1000);
        wait_rsp();
        @(negedge clk);

        // 5a: abort in second RUN cycle (grant 0, ptr -> 1)
        set_ops(0, 64'd2, 64'd2);
        ack_q.push_back('{0, 0});
        issue(4'b0001);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t5a_clear", 128'(mif.m_clear), 128'd1);
        chk("t5a_start", 128'(mif.m_start), 128'd0);
        chk("t5a_no_rsp", 128'(rsp_valid), 128'd0);
        chk("t5a_rsp_keep", rsp_data, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
        chk("t5a_busy", 128'(busy), 128'd1);
        @(negedge clk);
        chk("t5a_idle", 128'(busy), 128'd0);
        // ptr advanced: 0 and 1 both requesting, 1 must win
        set_ops(1, 64'd6, 64'd7);
        ack_q.push_back('{1, 0});
        rsp_q.push_back('{1, 128'd42});
        issue(4'b0011);
        wait_rsp();
        @(negedge clk);

        // 5b: abort coinciding with done (grant 2, ptr -> 3)
        set_ops(2, 64'd9, 64'd9);
        ack_q.push_back('{2, 0});
        issue(4'b0100);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (mif.m_done) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        chk("t5b_done_seen", 128'(seen), 128'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t5b_clear", 128'(mif.m_clear), 128'd1);
        chk("t5b_no_rsp", 128'(rsp_valid), 128'd0);
        chk("t5b_rsp_keep", rsp_data, 128'd42);
        @(negedge clk);
        // ptr at 3: requests 0 and 2 -> 0 wins
        set_ops(0, 64'd10, 64'd10);
        ack_q.push_back('{0, 0});
        rsp_q.push_back('{0, 128'd100});
        issue(4'b0101);
        wait_rsp();
        @(negedge clk);

        // 6: reset mid-RUN, then a clean request to 1
        set_ops(1, 64'd6, 64'd7);
        ack_q.push_back('{1, 0});
        issue(4'b0010);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 chk_all_zero("midrun_reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        set_ops(1, 64'd11, 64'd13);
        ack_q.push_back('{1, 0});
        rsp_q.push_back('{1, 128'd143});
        issue(4'b0010);
        wait_rsp();
        @(negedge clk);
        chk("t6_idle", 128'(busy), 128'd0);

        repeat (3) @(negedge clk);
        chk("ack_q_left", 128'(ack_q.size()), 128'd0);
        chk("rsp_q_left", 128'(rsp_q.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
